// File: rtl/can_error_frame_tx_if.sv
// Error-frame transmitter port bundle: bit-timing strobes, fault-confinement state, bus bit and status.
interface can_error_frame_tx_if;
    logic tx_point;
    logic sample_point;
    logic rx_bit;
    logic error_req;
    logic error_active;
    logic error_passive;
    logic bus_off;
    logic tx_bit;
    logic error_frame_active;
    logic sending_error_flag_passive;
    logic in_error_delimiter;
    logic dominant_overrun;
    logic delim_error;
    logic frame_done;

    modport master (
        output tx_point, sample_point, rx_bit, error_req, error_active, error_passive, bus_off,
        input  tx_bit, error_frame_active, sending_error_flag_passive, in_error_delimiter,
               dominant_overrun, delim_error, frame_done
    );

    modport slave (
        input  tx_point, sample_point, rx_bit, error_req, error_active, error_passive, bus_off,
        output tx_bit, error_frame_active, sending_error_flag_passive, in_error_delimiter,
               dominant_overrun, delim_error, frame_done
    );
endinterface

// File: rtl/can_error_frame_tx.sv
// Purpose: emits the CAN error frame (flag, recessive wait, delimiter, intermission) after a detected error.
// Latency: flag starts at the first tx_point after the request (same tx_point if coincident); pulses 1 clk after sample_point.
// Backpressure: none; paced by tx_point/sample_point strobes, bus_off aborts on the next clk.
module can_error_frame_tx #(
    parameter int FLAG_LEN  = 6,
    parameter int DELIM_LEN = 8,
    parameter int IFS_LEN   = 3,
    parameter int OVR_LEN   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    can_error_frame_tx_if.slave  bus
);
    localparam int CW = 8;

    typedef enum logic [2:0] {
        IDLE, ACTIVE_FLAG, PASSIVE_FLAG, WAIT_REC, DELIMITER, INTERMISSION
    } state_t;

    state_t        state, state_nxt, tx_state;
    logic          pending, pending_nxt;
    logic [CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [CW-1:0] eq_cnt, eq_cnt_nxt, eq_run;
    logic          last_bit, last_bit_nxt;
    logic [3:0]    dom_cnt, dom_cnt_nxt;
    logic          tx_bit, tx_bit_nxt;
    logic          ovr_p, ovr_nxt, derr_p, derr_nxt, done_p, done_nxt;
    logic          req_ok;
    // A flag is passive whenever the node is not error-active, so this input is informational only.
    logic          unused_passive;

    assign unused_passive = bus.error_passive;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pending  <= 1'b0;
            bit_cnt  <= '0;
            eq_cnt   <= '0;
            last_bit <= 1'b0;
            dom_cnt  <= '0;
            tx_bit   <= 1'b1;
            ovr_p    <= 1'b0;
            derr_p   <= 1'b0;
            done_p   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pending  <= pending_nxt;
            bit_cnt  <= bit_cnt_nxt;
            eq_cnt   <= eq_cnt_nxt;
            last_bit <= last_bit_nxt;
            dom_cnt  <= dom_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            ovr_p    <= ovr_nxt;
            derr_p   <= derr_nxt;
            done_p   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        bit_cnt_nxt  = bit_cnt;
        eq_cnt_nxt   = eq_cnt;
        last_bit_nxt = last_bit;
        dom_cnt_nxt  = dom_cnt;
        tx_bit_nxt   = tx_bit;
        ovr_nxt      = 1'b0;
        derr_nxt     = 1'b0;
        done_nxt     = 1'b0;
        eq_run       = '0;
        tx_state     = state;
        req_ok       = bus.error_req && !bus.bus_off;

        case (state)
            IDLE: begin
                if (req_ok) pending_nxt = 1'b1;
                // The starting flag drives tx_bit in the very tx_point that launches it.
                if (bus.tx_point && (pending || req_ok)) begin
                    pending_nxt = 1'b0;
                    state_nxt   = bus.error_active ? ACTIVE_FLAG : PASSIVE_FLAG;
                    bit_cnt_nxt = '0;
                    eq_cnt_nxt  = '0;
                    tx_state    = state_nxt;
                end
            end
            ACTIVE_FLAG: begin
                if (bus.sample_point) begin
                    if (bit_cnt == CW'(FLAG_LEN - 1)) begin
                        state_nxt   = WAIT_REC;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            PASSIVE_FLAG: begin
                if (bus.sample_point) begin
                    eq_run       = (eq_cnt != '0 && bus.rx_bit == last_bit) ? eq_cnt + 1'b1 : CW'(1);
                    last_bit_nxt = bus.rx_bit;
                    if (eq_run == CW'(FLAG_LEN)) begin
                        state_nxt  = WAIT_REC;
                        eq_cnt_nxt = '0;
                    end else begin
                        eq_cnt_nxt = eq_run;
                    end
                end
            end
            WAIT_REC: begin
                if (bus.sample_point) begin
                    if (bus.rx_bit) begin
                        state_nxt   = DELIMITER;
                        bit_cnt_nxt = CW'(1);
                        dom_cnt_nxt = '0;
                    end else if (dom_cnt == 4'(OVR_LEN - 1)) begin
                        ovr_nxt     = 1'b1;
                        dom_cnt_nxt = '0;
                    end else begin
                        dom_cnt_nxt = dom_cnt + 1'b1;
                    end
                end
            end
            DELIMITER: begin
                if (bus.sample_point) begin
                    if (!bus.rx_bit) begin
                        derr_nxt    = 1'b1;
                        pending_nxt = 1'b1;
                        state_nxt   = IDLE;
                        bit_cnt_nxt = '0;
                    end else if (bit_cnt == CW'(DELIM_LEN - 1)) begin
                        state_nxt   = INTERMISSION;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            INTERMISSION: begin
                if (bus.sample_point) begin
                    // A dominant bit here is another node's SOF: end the frame at once.
                    if (!bus.rx_bit || bit_cnt == CW'(IFS_LEN - 1)) begin
                        state_nxt   = IDLE;
                        done_nxt    = 1'b1;
                        bit_cnt_nxt = '0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (bus.tx_point) tx_bit_nxt = (tx_state != ACTIVE_FLAG);

        if (bus.bus_off) begin
            state_nxt    = IDLE;
            pending_nxt  = 1'b0;
            bit_cnt_nxt  = '0;
            eq_cnt_nxt   = '0;
            last_bit_nxt = 1'b0;
            dom_cnt_nxt  = '0;
            tx_bit_nxt   = 1'b1;
            ovr_nxt      = 1'b0;
            derr_nxt     = 1'b0;
            done_nxt     = 1'b0;
        end
    end

    assign bus.tx_bit                     = tx_bit;
    assign bus.error_frame_active         = (state != IDLE);
    assign bus.sending_error_flag_passive = (state == PASSIVE_FLAG);
    assign bus.in_error_delimiter         = (state == DELIMITER);
    assign bus.dominant_overrun           = ovr_p;
    assign bus.delim_error                = derr_p;
    assign bus.frame_done                 = done_p;
endmodule

// File: tb/tb_can_error_frame_tx.sv
// Bit-time driven bench: each bit is 4 clks (tx_point on clk 0, sample_point on clk 2) checked against a bit-level model.
`timescale 1ns/1ps
module tb_can_error_frame_tx;
    localparam int FLAG_LEN  = 6;
    localparam int DELIM_LEN = 8;
    localparam int IFS_LEN   = 3;
    localparam int OVR_LEN   = 8;
    localparam int NB        = 64;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    can_error_frame_tx_if ifc();

    can_error_frame_tx #(
        .FLAG_LEN(FLAG_LEN), .DELIM_LEN(DELIM_LEN), .IFS_LEN(IFS_LEN), .OVR_LEN(OVR_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    always #5 clk = ~clk;

    logic rx_seq  [NB];
    bit   exp_tx  [NB];
    bit   exp_efa [NB];
    bit   exp_pas [NB];
    bit   exp_del [NB];
    int   exp_ovr [NB];
    int   exp_derr[NB];
    int   exp_done[NB];
    logic obs_tx  [NB];
    logic obs_efa [NB];
    logic obs_pas [NB];
    logic obs_del [NB];
    int   obs_ovr [NB];
    int   obs_derr[NB];
    int   obs_done[NB];

    // Drive one clk worth of inputs; returns at the next negedge with outputs settled.
    task automatic cyc(input logic tp, input logic sp, input logic rx, input logic req);
        ifc.tx_point     = tp;
        ifc.sample_point = sp;
        ifc.rx_bit       = rx;
        ifc.error_req    = req;
        @(negedge clk);
    endtask

    function automatic bit run_equal(input int s, input int e);
        for (int i = s + 1; i <= e; i++) if (rx_seq[i] !== rx_seq[s]) return 1'b0;
        return 1'b1;
    endfunction

    // Bit-level reference: walk rx_seq from the flag start and mark what each bit time should show.
    task automatic build_model(input int start, input bit act);
        int b, e, w, dom, restart;
        for (int i = 0; i < NB; i++) begin
            exp_tx[i] = 1'b1; exp_efa[i] = 1'b0; exp_pas[i] = 1'b0; exp_del[i] = 1'b0;
            exp_ovr[i] = 0; exp_derr[i] = 0; exp_done[i] = 0;
        end
        b = start;
        while (b < NB) begin
            e = b + FLAG_LEN - 1;
            if (!act)
                while (e < NB && !run_equal(e - FLAG_LEN + 1, e)) e++;
            for (int i = b; i <= e && i < NB; i++) begin
                exp_efa[i] = 1'b1;
                if (act) exp_tx[i] = 1'b0;
                else     exp_pas[i] = 1'b1;
            end
            w = e + 1;
            dom = 0;
            while (w < NB && rx_seq[w] == 1'b0) begin
                exp_efa[w] = 1'b1;
                dom++;
                if (dom % OVR_LEN == 0) exp_ovr[w] = 1;
                w++;
            end
            if (w >= NB) break;
            exp_efa[w] = 1'b1;
            restart = -1;
            for (int k = w + 1; k < w + DELIM_LEN && k < NB; k++) begin
                exp_efa[k] = 1'b1;
                exp_del[k] = 1'b1;
                if (rx_seq[k] == 1'b0) begin
                    exp_derr[k] = 1;
                    restart = k + 1;
                    break;
                end
            end
            b = NB;
            if (restart >= 0) begin
                b = restart;
            end else begin
                for (int k = w + DELIM_LEN; k < w + DELIM_LEN + IFS_LEN && k < NB; k++) begin
                    exp_efa[k] = 1'b1;
                    if (rx_seq[k] == 1'b0 || k == w + DELIM_LEN + IFS_LEN - 1) begin
                        exp_done[k] = 1;
                        break;
                    end
                end
            end
        end
    endtask

    // req_c=0: request with the tx_point of bit 'start'; req_c=2: request mid-way through bit start-1.
    task automatic run_frame(input string name, input bit act, input int start, input int req_c,
                             input int extra_bit);
        int n_done_exp, n_done_obs;
        ifc.error_active  = act;
        ifc.error_passive = !act;
        build_model(start, act);
        for (int b = 0; b < NB; b++) begin
            obs_ovr[b] = 0; obs_derr[b] = 0; obs_done[b] = 0;
            for (int c = 0; c < 4; c++) begin
                logic req;
                req = (req_c == 0 && b == start && c == 0) ||
                      (req_c == 2 && b == start - 1 && c == 2) ||
                      (b == extra_bit && c == 2);
                cyc(c == 0, c == 2, rx_seq[b], req);
                if (c == 0) begin
                    obs_tx[b]  = ifc.tx_bit;
                    obs_efa[b] = ifc.error_frame_active;
                    obs_pas[b] = ifc.sending_error_flag_passive;
                    obs_del[b] = ifc.in_error_delimiter;
                end
                if (ifc.dominant_overrun !== 1'b0) obs_ovr[b]++;
                if (ifc.delim_error !== 1'b0)      obs_derr[b]++;
                if (ifc.frame_done !== 1'b0)       obs_done[b]++;
            end
        end
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        n_done_exp = 0;
        n_done_obs = 0;
        for (int b = 0; b < NB; b++) begin
            logic [3:0]  lvl_o, lvl_e;
            logic [11:0] pul_o, pul_e;
            lvl_o = {obs_tx[b], obs_efa[b], obs_pas[b], obs_del[b]};
            lvl_e = {exp_tx[b], exp_efa[b], exp_pas[b], exp_del[b]};
            pul_o = {4'(obs_ovr[b]), 4'(obs_derr[b]), 4'(obs_done[b])};
            pul_e = {4'(exp_ovr[b]), 4'(exp_derr[b]), 4'(exp_done[b])};
            n_done_exp += exp_done[b];
            n_done_obs += obs_done[b];
            checks++;
            if (lvl_o !== lvl_e) begin
                failures++;
                $display("FAIL %s levels bit %0d {tx,active,passive,delim}: got %b want %b", name, b, lvl_o, lvl_e);
            end
            checks++;
            if (pul_o !== pul_e) begin
                failures++;
                $display("FAIL %s pulses bit %0d {ovr,derr,done}: got %h want %h", name, b, pul_o, pul_e);
            end
        end
        checks++;
        if (n_done_obs !== n_done_exp) begin
            failures++;
            $display("FAIL %s frame_done total: got %0d want %0d", name, n_done_obs, n_done_exp);
        end
    endtask

    task automatic fill_rx(input int lo, input int hi, input logic v);
        for (int i = lo; i <= hi && i < NB; i++) rx_seq[i] = v;
    endtask

    task automatic test_reset;
        logic [6:0] o;
        rst = 1'b0;
        ifc.tx_point = 0; ifc.sample_point = 0; ifc.rx_bit = 1; ifc.error_req = 0;
        ifc.error_active = 1; ifc.error_passive = 0; ifc.bus_off = 0;
        repeat (3) @(negedge clk);
        o = {ifc.tx_bit, ifc.error_frame_active, ifc.sending_error_flag_passive, ifc.in_error_delimiter,
             ifc.dominant_overrun, ifc.delim_error, ifc.frame_done};
        checks++;
        if (o !== 7'b1000000) begin
            failures++;
            $display("FAIL reset outputs in reset: got %b want 1000000", o);
        end
        rst = 1'b1;
        repeat (2) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        o = {ifc.tx_bit, ifc.error_frame_active, ifc.sending_error_flag_passive, ifc.in_error_delimiter,
             ifc.dominant_overrun, ifc.delim_error, ifc.frame_done};
        checks++;
        if (o !== 7'b1000000) begin
            failures++;
            $display("FAIL reset outputs after release: got %b want 1000000", o);
        end
    endtask

    task automatic test_active_frame;
        fill_rx(0, NB - 1, 1'b1);
        fill_rx(0, FLAG_LEN - 1, 1'b0);
        run_frame("active", 1'b1, 0, 0, -1);
        checks++;
        if (obs_done[16] !== 1) begin
            failures++;
            $display("FAIL active frame_done at bit 16: got %0d want 1", obs_done[16]);
        end
    endtask

    task automatic test_passive_flag;
        fill_rx(0, NB - 1, 1'b1);
        fill_rx(0, 1, 1'b0);
        run_frame("passive", 1'b0, 0, 0, -1);
    endtask

    task automatic test_overrun;
        int n;
        fill_rx(0, NB - 1, 1'b1);
        fill_rx(0, FLAG_LEN + 15, 1'b0);
        run_frame("overrun", 1'b1, 0, 0, -1);
        n = 0;
        for (int b = 0; b < NB; b++) n += obs_ovr[b];
        checks++;
        if (n !== 2) begin
            failures++;
            $display("FAIL overrun pulse count: got %0d want 2", n);
        end
    endtask

    task automatic test_delim_error;
        fill_rx(0, NB - 1, 1'b1);
        fill_rx(0, 5, 1'b0);
        rx_seq[9] = 1'b0;
        fill_rx(10, 15, 1'b0);
        run_frame("delim_err", 1'b1, 0, 0, -1);
    endtask

    task automatic test_req_in_delimiter;
        fill_rx(0, NB - 1, 1'b1);
        fill_rx(0, 5, 1'b0);
        run_frame("req_in_delim", 1'b1, 0, 0, 8);
    endtask

    task automatic test_mid_bit_request;
        fill_rx(0, NB - 1, 1'b1);
        fill_rx(2, 7, 1'b0);
        run_frame("mid_bit_req", 1'b1, 2, 2, -1);
    endtask

    task automatic test_bus_off;
        logic seen;
        ifc.error_active = 1; ifc.error_passive = 0;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 4; c++) cyc(c == 0, c == 2, 1'b0, b == 0 && c == 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ifc.tx_bit, ifc.error_frame_active} !== 2'b01) begin
            failures++;
            $display("FAIL bus_off flag bit 3 in progress {tx,active}: got %b want 01", {ifc.tx_bit, ifc.error_frame_active});
        end
        ifc.bus_off = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ifc.tx_bit, ifc.error_frame_active} !== 2'b10) begin
            failures++;
            $display("FAIL bus_off abort {tx,active}: got %b want 10", {ifc.tx_bit, ifc.error_frame_active});
        end
        seen = 1'b0;
        for (int b = 0; b < 4; b++)
            for (int c = 0; c < 4; c++) begin
                cyc(c == 0, c == 2, 1'b1, c == 0 || c == 2);
                if (ifc.error_frame_active !== 1'b0 || ifc.tx_bit !== 1'b1) seen = 1'b1;
            end
        ifc.bus_off = 1'b0;
        for (int b = 0; b < 3; b++)
            for (int c = 0; c < 4; c++) begin
                cyc(c == 0, c == 2, 1'b1, 1'b0);
                if (ifc.error_frame_active !== 1'b0 || ifc.tx_bit !== 1'b1) seen = 1'b1;
            end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL bus_off requests ignored: frame activity seen=%b want 0", seen);
        end
    endtask

    task automatic test_random;
        for (int t = 0; t < 10; t++) begin
            bit act;
            int d, base;
            act = 1'($urandom_range(0, 1));
            fill_rx(0, NB - 1, 1'b1);
            if (act) begin
                d = $urandom_range(0, 17);
                fill_rx(0, FLAG_LEN - 1 + d, 1'b0);
                base = FLAG_LEN + d;
            end else begin
                d = $urandom_range(0, 8);
                for (int i = 0; i < d; i++) rx_seq[i] = 1'($urandom_range(0, 1));
                base = d + FLAG_LEN;
            end
            if ($urandom_range(0, 1) == 1) rx_seq[base + $urandom_range(1, 12)] = 1'b0;
            run_frame(act ? "random_active" : "random_passive", act, 0, 0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_active_frame();
        test_passive_flag();
        test_overrun();
        test_delim_error();
        test_req_in_delimiter();
        test_mid_bit_request();
        test_bus_off();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/can_error_frame_tx.md
Name: can_error_frame_tx

Overview:
- Transmit-side counterpart to the CAN error detector: once any error is detected, this block emits the error frame on the bus.
- Error frame sequence: active or passive error flag, wait for recessive bus, error delimiter, intermission.
- Sits between the error detector / fault-confinement state and the bit-stream TX mux. Its tx_bit overrides the frame transmitter while error_frame_active=1.

Parameters:
FLAG_LEN, 6, error flag length in bits (active: dominant bits sent; passive: equal consecutive bits required)
DELIM_LEN, 8, error delimiter length in recessive bits
IFS_LEN, 3, intermission length in recessive bits
OVR_LEN, 8, consecutive dominant bits after flag that raise dominant_overrun

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
tx_point  input  1  one-cycle strobe at bit start; tx_bit may change only here
sample_point  input  1  one-cycle strobe at bit sample point
rx_bit  input  1  sampled bus level (1=recessive)
error_req  input  1  pulse; OR of bit/stuff/form/ack/crc error
error_active  input  1  fault-confinement state: active
error_passive  input  1  fault-confinement state: passive
bus_off  input  1  fault-confinement state: bus-off
tx_bit  output  1  bit driven to bus
error_frame_active  output  1  high whenever state != IDLE
sending_error_flag_passive  output  1  high in PASSIVE_FLAG
in_error_delimiter  output  1  high in DELIMITER
dominant_overrun  output  1  1-cycle pulse per OVR_LEN dominant bits in WAIT_REC
delim_error  output  1  1-cycle pulse: dominant sampled in DELIMITER
frame_done  output  1  1-cycle pulse on return to IDLE from INTERMISSION

Behaviour:
- Reset: state=IDLE, tx_bit=1, pending=0, all counters 0, all pulse outputs 0.
- States: IDLE, ACTIVE_FLAG, PASSIVE_FLAG, WAIT_REC, DELIMITER, INTERMISSION.
- State transitions occur on sample_point. tx_bit is registered and updated only on tx_point:
  - 0 in ACTIVE_FLAG, 1 in every other state.
- IDLE:
  - error_req with bus_off=0 sets pending.
  - On tx_point with pending=1: clear pending; enter ACTIVE_FLAG if error_active=1 (priority), else PASSIVE_FLAG. tx_bit updates in that same tx_point cycle.
  - error_req and tx_point in the same cycle: flag starts at that tx_point.
- ACTIVE_FLAG: bit_cnt increments each sample_point. After the FLAG_LEN-th sample go to WAIT_REC, bit_cnt=0.
- PASSIVE_FLAG:
  - Track a run of equal rx_bit values: first sample sets eq_cnt=1; then eq_cnt++ if rx_bit==last_bit, else eq_cnt=1.
  - When eq_cnt reaches FLAG_LEN, go to WAIT_REC.
  - Bit errors from tx 1 / rx 0 are tolerated by the detector via sending_error_flag_passive.
- WAIT_REC:
  - rx_bit=1: go to DELIMITER with bit_cnt=1 (this bit counts as delimiter bit 1); dom_cnt=0.
  - rx_bit=0: dom_cnt++. On reaching OVR_LEN, pulse dominant_overrun and set dom_cnt=0, so the pulse repeats every OVR_LEN dominant bits. dom_cnt is 4 bits and saturation is not needed.
- DELIMITER:
  - rx_bit=1: bit_cnt++. At DELIM_LEN go to INTERMISSION, bit_cnt=0.
  - rx_bit=0: pulse delim_error, set pending, go to IDLE. A new flag starts at the next tx_point, chosen per current error_active.
- INTERMISSION:
  - Each recessive sample increments bit_cnt.
  - At IFS_LEN go to IDLE and pulse frame_done.
  - Dominant sample: immediate IDLE with frame_done pulse (treated as SOF from another node).
- error_req in any non-IDLE state is ignored; it does not set pending.
- bus_off=1 at any time:
  - On the next clk: state=IDLE, pending=0, counters cleared, tx_bit=1 (immediate, not gated by tx_point).
  - error_req is ignored while bus_off=1.
- Pulse outputs are high for exactly one clk. With no error frame in progress, the block is transparent: tx_bit=1, error_frame_active=0.
- Simultaneous sample_point and tx_point in one cycle: state update and tx_bit update both apply. tx_bit uses the pre-update state.

Test Plan:
- error_active=1, error_req pulse, rx_bit mirrors tx_bit -> tx_bit=0 for exactly 6 bit times starting next tx_point, then 8+3 recessive bits; frame_done pulses once ~17 bit times after flag start.
- error_passive=1, rx_bit=0,0,1,1,1,1,1,1 during flag -> sending_error_flag_passive=1 throughout; flag ends after the 6th consecutive recessive (8 bits total); tx_bit stays 1.
- Active flag, then rx_bit held 0 for 16 bits after flag -> dominant_overrun pulses twice (after dominant bits 8 and 16); rx_bit=1 then -> DELIMITER with in_error_delimiter=1.
- rx_bit=0 on delimiter bit 4 -> delim_error pulse; new 6-bit active flag starts at next tx_point.
- bus_off asserted on flag bit 3 -> next clk tx_bit=1, error_frame_active=0; subsequent error_req produces no frame.
- Second error_req during DELIMITER -> ignored; frame completes normally with a single frame_done.
